// File: rtl/mult_shift_pkg.sv
// Shared definitions for the sequential constant-coefficient multiplier.
package mult_shift_pkg;

  // FSM encoding, kept as explicit bit values for compatibility with legacy netlists.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_NCOEF  = 4;
  localparam int unsigned DEF_COEF_W = 4;

  // Default coefficient list, index 0 in the LSBs: {8, 7, 3, 1}.
  localparam logic [DEF_NCOEF*DEF_COEF_W-1:0] DEF_COEFS = {4'd8, 4'd7, 4'd3, 4'd1};

endpackage

// File: rtl/const_shift_mul.sv
// Combinational unsigned multiply of a sample by a small coefficient using
// conditional shifted adds only.
module const_shift_mul #(
  parameter int unsigned DW     = 8,
  parameter int unsigned COEF_W = 4
) (
  input  logic [DW-1:0]        i_d,
  input  logic [COEF_W-1:0]    i_coef,
  output logic [DW+COEF_W-1:0] o_prod
);

  localparam int unsigned PW = DW + COEF_W;

  // Sum the sample shifted by each set coefficient bit position.
  always_comb begin
    o_prod = '0;
    for (int unsigned b = 0; b < COEF_W; b++) begin
      if (i_coef[b]) begin
        o_prod = o_prod + (PW'(i_d) << b);
      end
    end
  end

endmodule

// File: rtl/mult_shift_seq.sv
// Sequential multiplier: each accepted sample is multiplied by NCOEF constant
// coefficients in turn, emitting one beat per coefficient (products or running sum)
// with a valid/ready output handshake and back-to-back sample streaming.
module mult_shift_seq
  import mult_shift_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned NCOEF  = DEF_NCOEF,
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter logic [NCOEF*COEF_W-1:0] COEFS = DEF_COEFS,
  localparam int unsigned OW    = DW + COEF_W + $clog2(NCOEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  input  logic          in_valid,
  input  logic          mode,
  output logic          input_grant,
  output logic [OW-1:0] out,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int unsigned IDX_W = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int unsigned PW    = DW + COEF_W;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [OW-1:0]      r_acc;
  logic [DW-1:0]      r_d;
  logic               r_mode;

  logic               w_run;
  logic [COEF_W-1:0]  w_coef;
  logic [PW-1:0]      w_prod;
  logic [OW-1:0]      w_prod_ext;
  logic [OW-1:0]      w_sum;
  logic               w_accept;

  assign w_run = (r_state == ST_RUN);

  // Select the coefficient for the current beat from the packed list.
  always_comb begin
    w_coef = '0;
    for (int unsigned k = 0; k < NCOEF; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_coef = COEFS[k*COEF_W +: COEF_W];
      end
    end
  end

  const_shift_mul #(
    .DW     (DW),
    .COEF_W (COEF_W)
  ) u_mul (
    .i_d    (r_d),
    .i_coef (w_coef),
    .o_prod (w_prod)
  );

  assign w_prod_ext = OW'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;

  assign out_valid   = w_run;
  assign out_last    = w_run && (r_idx == IDX_W'(NCOEF - 1));
  assign out         = w_run ? (r_mode ? w_sum : w_prod_ext) : '0;
  // The last beat being taken frees the datapath in the same edge, so a new
  // sample can be granted then without an idle cycle in between.
  assign input_grant = !w_run || (out_last && out_ready);
  assign w_accept    = in_valid && input_grant;

  // Sample capture, beat sequencing and running-sum accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_acc   <= '0;
      r_d     <= '0;
      r_mode  <= 1'b0;
    end else if (w_accept) begin
      r_state <= ST_RUN;
      r_idx   <= '0;
      r_acc   <= '0;
      r_d     <= d;
      r_mode  <= mode;
    end else if (w_run && out_ready) begin
      if (out_last) begin
        r_state <= ST_IDLE;
        r_idx   <= '0;
        r_acc   <= '0;
      end else begin
        r_idx   <= r_idx + IDX_W'(1);
        r_acc   <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_mult_shift_seq.sv
// Self-checking bench for mult_shift_seq with default parameters (OW = 14).
module tb_mult_shift_seq;

  localparam int unsigned OW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    d;
  logic          in_valid;
  logic          mode;
  logic          input_grant;
  logic [OW-1:0] out;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  mult_shift_seq dut (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .in_valid    (in_valid),
    .mode        (mode),
    .input_grant (input_grant),
    .out         (out),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned COEF[4] = '{1, 3, 7, 8};

  typedef struct {
    logic [7:0]         vd;
    logic               vmode;
    logic [3:0][OW-1:0] exp;
  } vec_t;

  typedef struct {
    int unsigned v;
    bit          last;
  } beat_t;

  vec_t  vecs[7];
  beat_t q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic beat(input string nm, input int unsigned v, input bit last, input bit grant);
    chk({nm, " valid"}, out_valid, 1);
    chk({nm, " out"}, out, v);
    chk({nm, " last"}, out_last, last);
    chk({nm, " grant"}, input_grant, grant);
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, " valid"}, out_valid, 0);
    chk({nm, " out"}, out, 0);
    chk({nm, " last"}, out_last, 0);
    chk({nm, " grant"}, input_grant, 1);
  endtask

  // Present one sample from idle, then take its four beats with ready held high.
  task automatic run_sample(input string nm, input logic [7:0] vd, input logic vm,
                            input logic [3:0][OW-1:0] exp);
    @(negedge clk);
    in_valid = 1'b1; d = vd; mode = vm; out_ready = 1'b1;
    #1;
    chk({nm, " pre-grant"}, input_grant, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0; d = $urandom; mode = $urandom;
      #1;
      beat($sformatf("%s b%0d", nm, k), exp[k], k == 3, k == 3);
    end
    @(negedge clk);
    #1;
    idle_chk({nm, " idle"});
  endtask

  initial begin
    int unsigned seq[8];
    int unsigned acc;
    bit          eg;

    vecs[0] = '{8'd10,  1'b0, {14'd80,   14'd70,   14'd30,   14'd10}};
    vecs[1] = '{8'd10,  1'b1, {14'd190,  14'd110,  14'd40,   14'd10}};
    vecs[2] = '{8'd255, 1'b1, {14'd4845, 14'd2805, 14'd1020, 14'd255}};
    vecs[3] = '{8'd0,   1'b1, {14'd0,    14'd0,    14'd0,    14'd0}};
    vecs[4] = '{8'd1,   1'b0, {14'd8,    14'd7,    14'd3,    14'd1}};
    vecs[5] = '{8'd200, 1'b0, {14'd1600, 14'd1400, 14'd600,  14'd200}};
    vecs[6] = '{8'd7,   1'b1, {14'd133,  14'd77,   14'd28,   14'd7}};

    rst = 1'b1; d = 8'hA5; in_valid = 1'b1; mode = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    idle_chk("reset");

    // Table-driven single samples.
    foreach (vecs[i])
      run_sample($sformatf("vec%0d", i), vecs[i].vd, vecs[i].vmode, vecs[i].exp);

    // Stall on beat 30 for three cycles.
    @(negedge clk);
    in_valid = 1'b1; d = 8'd10; mode = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; #1;
    beat("stall b0", 10, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0; #1;
      beat($sformatf("stall hold%0d", k), 30, 0, 0);
    end
    @(negedge clk); out_ready = 1'b1; #1; beat("stall b1", 30, 0, 0);
    @(negedge clk); #1; beat("stall b2", 70, 0, 0);
    @(negedge clk); #1; beat("stall b3", 80, 1, 1);
    @(negedge clk); #1; idle_chk("stall idle");

    // Back-to-back samples 3 then 11 with in_valid held.
    seq = '{3, 9, 21, 24, 11, 33, 77, 88};
    @(negedge clk);
    in_valid = 1'b1; d = 8'd3; mode = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      d = 8'd11; in_valid = (k < 4); #1;
      beat($sformatf("b2b %0d", k), seq[k], (k % 4) == 3, (k % 4) == 3);
    end
    @(negedge clk); #1; idle_chk("b2b idle");

    // in_valid, d and mode changes during RUN are ignored.
    @(negedge clk);
    in_valid = 1'b1; d = 8'd10; mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = (k < 3); d = 8'd99; mode = 1'b1; #1;
      beat($sformatf("ignore b%0d", k), vecs[0].exp[k], k == 3, k == 3);
    end
    @(negedge clk); in_valid = 1'b0; #1; idle_chk("ignore idle");

    // Reset mid-sample aborts it.
    @(negedge clk);
    in_valid = 1'b1; d = 8'd10; mode = 1'b0;
    @(negedge clk); in_valid = 1'b0; #1; beat("abort b0", 10, 0, 0);
    @(negedge clk); #1; beat("abort b1", 30, 0, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1; idle_chk("abort rst");
    run_sample("after rst", 8'd2, 1'b0, {14'd16, 14'd14, 14'd6, 14'd2});

    // Reset wins over a simultaneous accept.
    @(negedge clk); rst = 1'b1; in_valid = 1'b1; d = 8'd50;
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; #1; idle_chk("rst prio");

    // Randomized traffic against a beat-list model.
    q.delete();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) < 2);
      in_valid  = $urandom_range(0, 1);
      d         = $urandom;
      mode      = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (q.size() > 0) begin
        eg = q[0].last && out_ready;
        chk("rnd valid", out_valid, 1);
        chk("rnd out", out, q[0].v);
        chk("rnd last", out_last, q[0].last);
      end else begin
        eg = 1'b1;
        chk("rnd valid", out_valid, 0);
        chk("rnd out", out, 0);
        chk("rnd last", out_last, 0);
      end
      chk("rnd grant", input_grant, eg);
      if (rst) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && eg) begin
          acc = 0;
          for (int k = 0; k < 4; k++) begin
            acc += d * COEF[k];
            q.push_back('{v: (mode ? acc : d * COEF[k]), last: (k == 3)});
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
